// File: rtl/xadc_drp_package.sv
// Shared types and constants for the XADC DRP masters and their AXI-Stream outputs.
package xadc_drp_package;

    localparam int XADC_DRP_ADDR_WIDTH = 7;
    localparam int XADC_DRP_DATA_WIDTH = 16;

    typedef logic [XADC_DRP_ADDR_WIDTH-1:0] xadc_drp_addr_t;

    localparam xadc_drp_addr_t XADC_DRP_ADDR_VOLTAGE_CHANNEL = 7'h03;
    localparam xadc_drp_addr_t XADC_DRP_ADDR_CURRENT_CHANNEL = 7'h13;

    localparam int XADC_DRP_MULTI_MAX_CHANNELS  = 8;
    localparam int XADC_DRP_TIMEOUT_DEFAULT     = 64;
    localparam int XADC_DRP_TUSER_FRAME_ERR_BIT = 0;
    localparam int XADC_DRP_TUSER_OVERRUN_BIT   = 1;
    localparam int XADC_DRP_TUSER_WIDTH         = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DRDY,
        SEND
    } xadc_drp_multi_state_t;

endpackage

// File: rtl/axis_interface.sv
// Generic AXI-Stream bundle; master drives the payload, slave drives tready.
interface axis_interface #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 2,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic [ID_WIDTH-1:0]     tid;
    logic [DEST_WIDTH-1:0]   tdest;
    logic [USER_WIDTH-1:0]   tuser;
    logic                    tvalid;
    logic                    tready;

    modport master (output tdata, tkeep, tlast, tid, tdest, tuser, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tid, tdest, tuser, tvalid, output tready);
endinterface

// File: rtl/xadc_drp_read_timer.sv
// Loadable down-counter for DRP read timeouts; o_expired is high once the count reaches zero.
module xadc_drp_read_timer
    import xadc_drp_package::*;
#(
    parameter int TIMEOUT_CYCLES = XADC_DRP_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CNT_W'(TIMEOUT_CYCLES - 1);
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_expired = (r_count == '0);
endmodule

// File: rtl/xadc_drp_axis_multi_channel.sv
// On each XADC EOS reads NUM_CHANNELS DRP registers and emits them as one packed AXIS beat.
// Optional macro XADC_DRP_MULTI_OVERRUN_PORT_EN exposes the overrun counter and tuser[1] flag.
module xadc_drp_axis_multi_channel
    import xadc_drp_package::*;
#(
    parameter int             NUM_CHANNELS      = 2,
    parameter xadc_drp_addr_t CHANNEL_ADDRS [NUM_CHANNELS] =
        '{XADC_DRP_ADDR_VOLTAGE_CHANNEL, XADC_DRP_ADDR_CURRENT_CHANNEL},
    parameter int             TIMEOUT_CYCLES    = XADC_DRP_TIMEOUT_DEFAULT,
    parameter int             OVERRUN_CNT_WIDTH = 16
) (
    input  logic                           xadc_dclk,
    input  logic                           xadc_reset,
    output xadc_drp_addr_t                 xadc_daddr,
    output logic                           xadc_den,
    input  logic                           xadc_drdy,
    input  logic [XADC_DRP_DATA_WIDTH-1:0] xadc_do,
    input  logic                           xadc_eos,
    axis_interface.master                  sample_stream,
    output logic                           timeout_err
`ifdef XADC_DRP_MULTI_OVERRUN_PORT_EN
    ,
    output logic [OVERRUN_CNT_WIDTH-1:0]   overrun_count
`endif
);
    localparam int W     = XADC_DRP_DATA_WIDTH;
    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

    if (NUM_CHANNELS < 1 || NUM_CHANNELS > XADC_DRP_MULTI_MAX_CHANNELS ||
        TIMEOUT_CYCLES < 2 || OVERRUN_CNT_WIDTH < 1) begin : g_bad_param
        $error("xadc_drp_axis_multi_channel: parameter out of range");
    end

    xadc_drp_multi_state_t            r_state;
    logic [IDX_W-1:0]                 r_idx;
    xadc_drp_addr_t                   r_daddr;
    logic                             r_den;
    logic [NUM_CHANNELS*W-1:0]        r_tdata;
    logic [XADC_DRP_TUSER_WIDTH-1:0]  r_tuser;
    logic                             r_tvalid;
    logic                             r_frame_err;
    logic                             r_timeout_err;
    logic                             r_eos_pending;

    logic             w_start, w_step, w_timed_out, w_last, w_timer_load, w_expired;
    logic             w_overrun, w_overrun_flag;
    logic [IDX_W-1:0] w_next_idx;

    assign w_start      = (r_state == IDLE) && (xadc_eos || r_eos_pending);
    assign w_step       = (r_state == WAIT_DRDY) && (xadc_drdy || w_expired);
    assign w_timed_out  = w_step && !xadc_drdy;
    assign w_last       = (r_idx == LAST_IDX);
    assign w_next_idx   = r_idx + IDX_W'(1);
    assign w_timer_load = w_start || (w_step && !w_last);
    // A second EOS while one is already queued outside IDLE is lost.
    assign w_overrun    = xadc_eos && (r_state != IDLE) && r_eos_pending;

    xadc_drp_read_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_read_timer (
        .clk       (xadc_dclk),
        .rst       (xadc_reset),
        .i_load    (w_timer_load),
        .o_expired (w_expired)
    );

    always_ff @(posedge xadc_dclk or posedge xadc_reset) begin
        if (xadc_reset) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_daddr       <= CHANNEL_ADDRS[0];
            r_den         <= 1'b0;
            r_tdata       <= '0;
            r_tuser       <= '0;
            r_tvalid      <= 1'b0;
            r_frame_err   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_eos_pending <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        // Starting from a queued EOS consumes it; a fresh EOS in that cycle re-queues.
                        r_eos_pending <= r_eos_pending && xadc_eos;
                        r_idx         <= '0;
                        r_daddr       <= CHANNEL_ADDRS[0];
                        r_den         <= 1'b1;
                        r_frame_err   <= 1'b0;
                        r_state       <= WAIT_DRDY;
                    end
                end
                WAIT_DRDY: begin
                    r_den <= 1'b0;
                    if (xadc_eos) r_eos_pending <= 1'b1;
                    if (w_step) begin
                        for (int k = 0; k < NUM_CHANNELS; k++) begin
                            if (r_idx == IDX_W'(k)) begin
                                r_tdata[(NUM_CHANNELS-k)*W-1 -: W] <= xadc_drdy ? xadc_do : '0;
                            end
                        end
                        if (w_timed_out) begin
                            r_frame_err   <= 1'b1;
                            r_timeout_err <= 1'b1;
                        end
                        if (w_last) begin
                            r_tvalid <= 1'b1;
                            r_tuser[XADC_DRP_TUSER_FRAME_ERR_BIT] <= r_frame_err || w_timed_out;
                            r_tuser[XADC_DRP_TUSER_OVERRUN_BIT]   <= w_overrun_flag;
                            r_state  <= SEND;
                        end else begin
                            r_idx   <= w_next_idx;
                            r_daddr <= CHANNEL_ADDRS[w_next_idx];
                            r_den   <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (xadc_eos) r_eos_pending <= 1'b1;
                    if (sample_stream.tready) begin
                        r_tvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef XADC_DRP_MULTI_OVERRUN_PORT_EN
    logic [OVERRUN_CNT_WIDTH-1:0] r_overrun_cnt;
    logic                         r_overrun_seen;

    always_ff @(posedge xadc_dclk or posedge xadc_reset) begin
        if (xadc_reset) begin
            r_overrun_cnt  <= '0;
            r_overrun_seen <= 1'b0;
        end else begin
            if (w_overrun && (r_overrun_cnt != '1)) begin
                r_overrun_cnt <= r_overrun_cnt + OVERRUN_CNT_WIDTH'(1);
            end
            if (w_step && w_last) begin
                r_overrun_seen <= 1'b0;
            end else if (w_overrun) begin
                r_overrun_seen <= 1'b1;
            end
        end
    end

    assign w_overrun_flag = r_overrun_seen || w_overrun;
    assign overrun_count  = r_overrun_cnt;
`else
    assign w_overrun_flag = 1'b0;
`endif

    assign xadc_daddr           = r_daddr;
    assign xadc_den             = r_den;
    assign timeout_err          = r_timeout_err;
    assign sample_stream.tdata  = r_tdata;
    assign sample_stream.tuser  = r_tuser;
    assign sample_stream.tvalid = r_tvalid;
    assign sample_stream.tlast  = 1'b1;
    assign sample_stream.tkeep  = '1;
    assign sample_stream.tid    = '0;
    assign sample_stream.tdest  = '0;
endmodule
